// File: rtl/rx_ring_writer.sv
// rtl/rx_ring_writer.sv - moves GMII receive frames into a host ring buffer over the PCIe master write queue
module rx_ring_writer #(
    parameter int SLOTS     = 16,
    parameter int SLOT_LOG2 = 11,
    parameter int BAR       = 0
) (
    input  logic        pcie_clk,
    input  logic        sys_rst_n,
    input  logic [8:0]  phy_dout,
    input  logic        phy_empty,
    output logic        phy_rd_en,
    output logic [17:0] mst_din,
    input  logic        mst_full,
    output logic        mst_wr_en,
    input  logic [6:0]  slv_bar_i,
    input  logic        slv_ce_i,
    input  logic        slv_we_i,
    input  logic [3:0]  slv_adr_i,
    input  logic [15:0] slv_dat_i,
    input  logic [1:0]  slv_sel_i,
    output logic [15:0] slv_dat_o,
    output logic        irq_frame
);
    localparam int          IDXW = $clog2(SLOTS);
    localparam logic [15:0] MAXB = 16'((1 << SLOT_LOG2) - 2);
    localparam logic [31:0] SLOT_MASK = ~32'((1 << SLOT_LOG2) - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_AH, S_AL, S_DATA, S_LH, S_LL, S_LEN, S_COMMIT, S_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic              en_q, en_d;
    logic [15:0]       base_lo_q, base_lo_d, base_hi_q, base_hi_d;
    logic [IDXW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [15:0]       drop_q, drop_d;
    logic [31:0]       addr_q, addr_d;
    logic [15:0]       len_q, len_d, wbuf_q, wbuf_d;
    logic              have_q, have_d, rd_pend_q, rd_pend_d;
    logic [8:0]        byte_q, byte_d;
    logic [15:0]       rdata_q, rdata_d;

    logic              hit, consume, pop_ok, commit, drop_inc;
    logic [IDXW-1:0]   tail_inc;
    logic [31:0]       addr2, slot_base;
    logic [15:0]       head_w;

    function automatic logic [15:0] bmerge(input logic [15:0] old, input logic [15:0] dat,
                                           input logic [1:0] sel);
        return {sel[1] ? dat[15:8] : old[15:8], sel[0] ? dat[7:0] : old[7:0]};
    endfunction

    assign hit       = slv_ce_i & slv_bar_i[BAR];
    assign tail_inc  = tail_q + IDXW'(1);
    assign addr2     = addr_q + 32'd2;
    assign slot_base = ({base_hi_q, base_lo_q} & SLOT_MASK) + (32'(tail_q) << SLOT_LOG2);
    assign head_w    = bmerge(16'(head_q), slv_dat_i, slv_sel_i);
    assign slv_dat_o = rdata_q;

    always_comb begin
        state_d   = state_q;
        en_d      = en_q;
        base_lo_d = base_lo_q;
        base_hi_d = base_hi_q;
        head_d    = head_q;
        addr_d    = addr_q;
        len_d     = len_q;
        wbuf_d    = wbuf_q;
        byte_d    = byte_q;
        have_d    = have_q;
        rdata_d   = 16'h0000;
        phy_rd_en = 1'b0;
        mst_wr_en = 1'b0;
        mst_din   = 18'h0;
        irq_frame = 1'b0;
        consume   = 1'b0;
        pop_ok    = 1'b0;
        commit    = 1'b0;
        drop_inc  = 1'b0;

        case (state_q)
            S_IDLE: begin
                pop_ok = 1'b1;
                if (have_q) begin
                    // the start byte stays held: it becomes the first data byte
                    if (byte_q[8]) state_d = S_START;
                    else           consume = 1'b1;
                end
            end
            S_START: begin
                if (!en_q) begin
                    consume = 1'b1;
                    state_d = S_DRAIN;
                end else if (tail_inc == head_q) begin
                    consume  = 1'b1;
                    drop_inc = 1'b1;
                    state_d  = S_DRAIN;
                end else begin
                    addr_d  = slot_base;
                    len_d   = 16'h0000;
                    wbuf_d  = 16'h0000;
                    state_d = S_AH;
                end
            end
            S_AH, S_AL, S_LH, S_LL, S_LEN: begin
                case (state_q)
                    S_AH:    mst_din = {2'b10, addr2[31:16]};
                    S_AL:    mst_din = {2'b10, addr2[15:0]};
                    S_LH:    mst_din = {2'b10, addr_q[31:16]};
                    S_LL:    mst_din = {2'b10, addr_q[15:0]};
                    default: mst_din = {2'b01, len_q};
                endcase
                mst_wr_en = !mst_full;
                if (!mst_full) state_d = state_t'(state_q + 4'd1);
            end
            S_DATA: begin
                pop_ok = !mst_full;
                if (have_q) begin
                    if (!byte_q[8]) begin
                        mst_din = {2'b01, wbuf_q};
                        if (!mst_full) begin
                            mst_wr_en = 1'b1;
                            consume   = 1'b1;
                            state_d   = S_LH;
                        end
                    end else if (len_q >= MAXB) begin
                        consume = 1'b1;
                    end else if (len_q[0]) begin
                        wbuf_d[7:0] = byte_q[7:0];
                        len_d       = len_q + 16'd1;
                        consume     = 1'b1;
                    end else if (len_q == 16'h0000) begin
                        wbuf_d  = {byte_q[7:0], 8'h00};
                        len_d   = 16'd1;
                        consume = 1'b1;
                    end else begin
                        // a completed pair is only pushed once we know it is not the last word
                        mst_din = {2'b00, wbuf_q};
                        if (!mst_full) begin
                            mst_wr_en = 1'b1;
                            wbuf_d    = {byte_q[7:0], 8'h00};
                            len_d     = len_q + 16'd1;
                            consume   = 1'b1;
                        end
                    end
                end
            end
            S_COMMIT: begin
                commit    = 1'b1;
                irq_frame = 1'b1;
                state_d   = S_IDLE;
            end
            S_DRAIN: begin
                pop_ok = 1'b1;
                if (have_q) begin
                    consume = 1'b1;
                    if (!byte_q[8]) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        phy_rd_en = pop_ok && !phy_empty && !have_q && !rd_pend_q;
        rd_pend_d = phy_rd_en;
        if (rd_pend_q) begin
            have_d = 1'b1;
            byte_d = phy_dout;
        end else if (consume) begin
            have_d = 1'b0;
        end

        tail_d = commit ? tail_inc : tail_q;
        drop_d = (drop_inc && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;

        // register writes come last so a host clear overrides commit and drop counting
        if (hit && slv_we_i) begin
            case (slv_adr_i)
                4'd0: if (slv_sel_i[0]) begin
                    en_d = slv_dat_i[0];
                    if (slv_dat_i[1]) begin
                        tail_d = '0;
                        drop_d = 16'h0000;
                    end
                end
                4'd1: base_lo_d = bmerge(base_lo_q, slv_dat_i, slv_sel_i);
                4'd2: base_hi_d = bmerge(base_hi_q, slv_dat_i, slv_sel_i);
                4'd3: head_d    = head_w[IDXW-1:0];
                4'd5: if (|slv_sel_i) drop_d = 16'h0000;
                default: ;
            endcase
        end else if (hit) begin
            case (slv_adr_i)
                4'd0:    rdata_d = {15'h0000, en_q};
                4'd1:    rdata_d = base_lo_q;
                4'd2:    rdata_d = base_hi_q;
                4'd3:    rdata_d = 16'(head_q);
                4'd4:    rdata_d = 16'(tail_q);
                4'd5:    rdata_d = drop_q;
                default: rdata_d = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= S_IDLE;
            en_q      <= 1'b0;
            base_lo_q <= 16'h0000;
            base_hi_q <= 16'h0000;
            head_q    <= '0;
            tail_q    <= '0;
            drop_q    <= 16'h0000;
            addr_q    <= 32'h0;
            len_q     <= 16'h0000;
            wbuf_q    <= 16'h0000;
            byte_q    <= 9'h000;
            have_q    <= 1'b0;
            rd_pend_q <= 1'b0;
            rdata_q   <= 16'h0000;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            base_lo_q <= base_lo_d;
            base_hi_q <= base_hi_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            drop_q    <= drop_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            wbuf_q    <= wbuf_d;
            byte_q    <= byte_d;
            have_q    <= have_d;
            rd_pend_q <= rd_pend_d;
            rdata_q   <= rdata_d;
        end
    end
endmodule

// File: tb/tb_rx_ring_writer.sv
// tb/tb_rx_ring_writer.sv - self-checking bench for rx_ring_writer against a frame-level ring model
module tb_rx_ring_writer;
    logic        pcie_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [8:0]  phy_dout = 9'h000;
    logic        phy_empty = 1'b1;
    logic        phy_rd_en;
    logic [17:0] mst_din;
    logic        mst_full = 1'b0;
    logic        mst_wr_en;
    logic [6:0]  slv_bar_i = 7'h01;
    logic        slv_ce_i = 1'b0;
    logic        slv_we_i = 1'b0;
    logic [3:0]  slv_adr_i = 4'h0;
    logic [15:0] slv_dat_i = 16'h0000;
    logic [1:0]  slv_sel_i = 2'b00;
    logic [15:0] slv_dat_o;
    logic        irq_frame;

    rx_ring_writer dut (
        .pcie_clk(pcie_clk), .sys_rst_n(sys_rst_n), .phy_dout(phy_dout), .phy_empty(phy_empty),
        .phy_rd_en(phy_rd_en), .mst_din(mst_din), .mst_full(mst_full), .mst_wr_en(mst_wr_en),
        .slv_bar_i(slv_bar_i), .slv_ce_i(slv_ce_i), .slv_we_i(slv_we_i), .slv_adr_i(slv_adr_i),
        .slv_dat_i(slv_dat_i), .slv_sel_i(slv_sel_i), .slv_dat_o(slv_dat_o), .irq_frame(irq_frame)
    );

    always #5 pcie_clk = ~pcie_clk;

    int          checks = 0, errors = 0;
    logic [8:0]  fifo_q[$];
    logic [17:0] exp_q[$];
    logic [7:0]  fb[$];
    bit          rd_seen = 1'b0;
    int          pops = 0, pushes = 0, irqs = 0, exp_irqs = 0;
    int          full_mode = 0, gap_mode = 0;
    logic [17:0] mon_exp, last_push = 18'h0;
    int          tail_m = 0, head_m = 0, drop_m = 0;
    bit          en_m = 1'b0;
    logic [31:0] base_m = 32'h0;
    logic [15:0] rv;
    int          p0, w0;

    // monitor: every push is checked in order against the model's expected words
    always @(negedge pcie_clk) begin
        rd_seen = phy_rd_en;
        if (sys_rst_n) begin
            if (phy_rd_en) begin
                pops++;
                checks++;
                assert (phy_empty === 1'b0) else begin errors++; $error("FAIL pop_when_empty got rd_en=1 with empty=1 expected no pop"); end
            end
            if (mst_wr_en) begin
                pushes++;
                last_push = mst_din;
                checks++;
                assert (mst_full === 1'b0) else begin errors++; $error("FAIL push_when_full got wr_en=1 with full=1 expected no push"); end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_push got %h expected no push", mst_din);
                end else begin
                    mon_exp = exp_q.pop_front();
                    checks++;
                    assert (mst_din === mon_exp) else begin errors++; $error("FAIL push_word got %h expected %h", mst_din, mon_exp); end
                end
            end
            if (irq_frame) irqs++;
        end
    end

    // receive FIFO and master queue back-pressure models
    always @(posedge pcie_clk) begin
        #1;
        if (rd_seen) phy_dout = (fifo_q.size() != 0) ? fifo_q.pop_front() : 9'h000;
        phy_empty = (fifo_q.size() == 0) || (gap_mode != 0 && $urandom_range(0, 3) == 0);
        case (full_mode)
            0:       mst_full = 1'b0;
            1:       mst_full = ($urandom_range(0, 3) == 0);
            default: mst_full = 1'b1;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin errors++; $error("FAIL %s got %h expected %h", tag, obs, exp); end
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] s);
        @(posedge pcie_clk); #1;
        slv_ce_i = 1'b1; slv_we_i = 1'b1; slv_adr_i = a; slv_dat_i = d; slv_sel_i = s;
        @(posedge pcie_clk); #1;
        slv_ce_i = 1'b0; slv_we_i = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [15:0] d);
        @(posedge pcie_clk); #1;
        slv_ce_i = 1'b1; slv_we_i = 1'b0; slv_adr_i = a;
        @(posedge pcie_clk); #1;
        d = slv_dat_o;
        slv_ce_i = 1'b0;
    endtask

    task automatic rand_frame(input int n);
        fb.delete();
        for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
    endtask

    task automatic inject();
        int gaps = $urandom_range(0, 2);
        for (int i = 0; i < gaps; i++) fifo_q.push_back({1'b0, 8'($urandom)});
        foreach (fb[i]) fifo_q.push_back({1'b1, fb[i]});
        fifo_q.push_back({1'b0, 8'($urandom)});
    endtask

    // frame-level view: slot address, truncated payload as big-endian words, then address and length
    task automatic model_frame();
        logic [31:0] a, a2;
        int          m;
        logic [7:0]  lo;
        if (!en_m) return;
        if (((tail_m + 1) % 16) == head_m) begin
            if (drop_m < 65535) drop_m++;
            return;
        end
        a  = (base_m & 32'hFFFF_F800) + 32'(tail_m) * 32'd2048;
        a2 = a + 32'd2;
        exp_q.push_back({2'b10, a2[31:16]});
        exp_q.push_back({2'b10, a2[15:0]});
        m = (fb.size() > 2046) ? 2046 : fb.size();
        for (int i = 0; i < m; i += 2) begin
            lo = (i + 1 < m) ? fb[i+1] : 8'h00;
            exp_q.push_back({(i + 2 >= m) ? 2'b01 : 2'b00, fb[i], lo});
        end
        exp_q.push_back({2'b10, a[31:16]});
        exp_q.push_back({2'b10, a[15:0]});
        exp_q.push_back({2'b01, 16'(m)});
        tail_m = (tail_m + 1) % 16;
        exp_irqs++;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0) && t < 30000) begin
            @(posedge pcie_clk);
            t++;
        end
        repeat (20) @(posedge pcie_clk);
        chk("drain_timeout", (t < 30000) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic send();
        model_frame();
        inject();
        wait_idle();
    endtask

    initial begin
        repeat (3) @(posedge pcie_clk);
        #1;
        chk("rst_rd_en", 32'(phy_rd_en), 0);
        chk("rst_wr_en", 32'(mst_wr_en), 0);
        chk("rst_irq", 32'(irq_frame), 0);
        chk("rst_dat_o", 32'(slv_dat_o), 0);
        sys_rst_n = 1'b1;
        for (int r = 0; r < 6; r++) begin
            rd(4'(r), rv);
            chk("rst_reg", 32'(rv), 0);
        end

        // spec example: BASE=0x0010_0000, 5-byte frame
        wr(4'd1, 16'h0000, 2'b11);
        wr(4'd2, 16'h0010, 2'b11);
        wr(4'd0, 16'h0001, 2'b11);
        base_m = 32'h0010_0000; en_m = 1'b1;
        fb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        exp_q = '{18'h20010, 18'h20002, 18'h01122, 18'h03344, 18'h15500, 18'h20010, 18'h20000, 18'h10005};
        tail_m = 1; exp_irqs = 1;
        inject();
        wait_idle();
        rd(4'd4, rv); chk("t1_tail", 32'(rv), 1);
        chk("t1_irq", irqs, 1);

        // clear, then fill the ring under random gaps and back-pressure
        wr(4'd0, 16'h0003, 2'b11);
        tail_m = 0; drop_m = 0;
        rd(4'd0, rv); chk("ctrl_selfclr", 32'(rv), 1);
        rd(4'd4, rv); chk("clr_tail", 32'(rv), 0);
        gap_mode = 1; full_mode = 1;
        for (int f = 0; f < 15; f++) begin
            rand_frame($urandom_range(1, 40));
            send();
        end
        rd(4'd4, rv); chk("fill_tail", 32'(rv), 32'(tail_m));
        w0 = pushes;
        rand_frame(9);
        send();
        chk("full_no_push", pushes - w0, 0);
        rd(4'd5, rv); chk("full_drop", 32'(rv), 32'(drop_m));
        rd(4'd4, rv); chk("full_tail", 32'(rv), 15);

        // wrap: commit into slot 15, then slot 0 sits at BASE
        wr(4'd3, 16'h0004, 2'b11);
        head_m = 4;
        rd(4'd3, rv); chk("head_rb", 32'(rv), 4);
        rand_frame(7); send();
        rd(4'd4, rv); chk("wrap_tail", 32'(rv), 0);
        rand_frame(4); send();
        rd(4'd4, rv); chk("wrap_next", 32'(rv), 1);

        // truncation of an oversized frame
        gap_mode = 0; full_mode = 0;
        rand_frame(3000); send();
        chk("trunc_len", 32'(last_push), 32'h107FE);

        // long stall mid-frame
        rand_frame(40);
        model_frame();
        inject();
        repeat (40) @(posedge pcie_clk);
        full_mode = 2;
        repeat (2) @(posedge pcie_clk);
        p0 = pops; w0 = pushes;
        repeat (50) @(posedge pcie_clk);
        chk("stall_no_pop", pops - p0, 0);
        chk("stall_no_push", pushes - w0, 0);
        full_mode = 0;
        wait_idle();

        // disabled ring: frame drained, nothing counted
        wr(4'd0, 16'h0000, 2'b11);
        en_m = 1'b0;
        w0 = pushes;
        rand_frame(6); send();
        chk("dis_no_push", pushes - w0, 0);
        rd(4'd4, rv); chk("dis_tail", 32'(rv), 32'(tail_m));

        // byte enables, unmapped, non-hit, drop clear
        wr(4'd2, 16'hABCD, 2'b10);
        rd(4'd2, rv); chk("be_hi", 32'(rv), 32'hAB10);
        wr(4'd9, 16'h1234, 2'b11);
        rd(4'd9, rv); chk("unmapped", 32'(rv), 0);
        slv_bar_i = 7'h02;
        rd(4'd2, rv); chk("nonhit", 32'(rv), 0);
        slv_bar_i = 7'h01;
        rd(4'd5, rv); chk("drop_pre", 32'(rv), 32'(drop_m));
        wr(4'd5, 16'h0000, 2'b11);
        rd(4'd5, rv); chk("drop_wclr", 32'(rv), 0);

        // reset mid-frame
        wr(4'd2, 16'h0010, 2'b11);
        wr(4'd0, 16'h0001, 2'b11);
        rand_frame(30);
        inject();
        repeat (30) @(posedge pcie_clk);
        #2;
        sys_rst_n = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        @(posedge pcie_clk); #2;
        chk("mrst_rd_en", 32'(phy_rd_en), 0);
        chk("mrst_wr_en", 32'(mst_wr_en), 0);
        chk("mrst_irq", 32'(irq_frame), 0);
        chk("mrst_dat_o", 32'(slv_dat_o), 0);
        @(posedge pcie_clk); #1;
        sys_rst_n = 1'b1;
        tail_m = 0; head_m = 0; drop_m = 0; en_m = 1'b0; base_m = 32'h0;
        for (int r = 0; r < 6; r++) begin
            rd(4'(r), rv);
            chk("mrst_reg", 32'(rv), 0);
        end
        wr(4'd2, 16'h0020, 2'b11);
        wr(4'd0, 16'h0001, 2'b11);
        base_m = 32'h0020_0000; en_m = 1'b1;
        rand_frame(11); send();
        rd(4'd4, rv); chk("post_rst_tail", 32'(rv), 1);
        chk("irq_total", irqs, exp_irqs);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
